// File: rtl/arch_reg_dump.sv
// arch_reg_dump: after stop, drains the pipeline then streams {index, value} for every
// architectural register through RAT->PRF lookups. Define DUMP_CHECK_EN for reference compare.
module arch_reg_dump #(
  parameter int NUM_AREG   = 8,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 5,
  parameter int SETTLE_CYC = 4,
  parameter int PRF_RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stop,
  output logic [$clog2(NUM_AREG)-1:0]   rat_idx,
  input  logic [TAG_W-1:0]              rat_tag,
  output logic [TAG_W-1:0]              prf_raddr,
  input  logic [DATA_W-1:0]             prf_rdata,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [$clog2(NUM_AREG)-1:0]   dump_idx,
  output logic [DATA_W-1:0]             dump_data,
  output logic                          dump_done
`ifdef DUMP_CHECK_EN
  ,
  input  logic [NUM_AREG*DATA_W-1:0]    ref_data,
  output logic [$clog2(NUM_AREG+1)-1:0] mismatch_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_AREG);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RD_W  = (PRF_RD_LAT > 1) ? $clog2(PRF_RD_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AREG - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYC > 1) ? SETTLE_CYC - 1 : 0);
  localparam logic [RD_W-1:0]  RD_LAST  = RD_W'((PRF_RD_LAT > 1) ? PRF_RD_LAT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    LOOKUP,
    READ,
    SEND,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [SET_W-1:0]  settle_cnt_reg, settle_cnt_next;
  logic [RD_W-1:0]   rd_cnt_reg, rd_cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [TAG_W-1:0]  raddr_reg, raddr_next;
  logic [IDX_W-1:0]  dump_idx_reg, dump_idx_next;
  logic [DATA_W-1:0] dump_data_reg, dump_data_next;
  logic              beat_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      rd_cnt_reg     <= '0;
      idx_reg        <= '0;
      raddr_reg      <= '0;
      dump_idx_reg   <= '0;
      dump_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      rd_cnt_reg     <= rd_cnt_next;
      idx_reg        <= idx_next;
      raddr_reg      <= raddr_next;
      dump_idx_reg   <= dump_idx_next;
      dump_data_reg  <= dump_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    rd_cnt_next     = rd_cnt_reg;
    idx_next        = idx_reg;
    raddr_next      = raddr_reg;
    dump_idx_next   = dump_idx_reg;
    dump_data_next  = dump_data_reg;
    case (state_reg)
      IDLE: begin
        if (stop) begin
          state_next      = DRAIN;
          settle_cnt_next = '0;
        end
      end
      DRAIN: begin
        // SETTLE_CYC of 0 or 1 both leave after a single drain cycle
        if (settle_cnt_reg == SET_LAST) begin
          state_next = LOOKUP;
          idx_next   = '0;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end
      LOOKUP: begin
        raddr_next = rat_tag;
        if (PRF_RD_LAT == 0) begin
          dump_data_next = prf_rdata;
          dump_idx_next  = idx_reg;
          state_next     = SEND;
        end else begin
          rd_cnt_next = '0;
          state_next  = READ;
        end
      end
      READ: begin
        if (rd_cnt_reg == RD_LAST) begin
          dump_data_next = prf_rdata;
          dump_idx_next  = idx_reg;
          state_next     = SEND;
        end else begin
          rd_cnt_next = rd_cnt_reg + 1'b1;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = LOOKUP;
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // PRF address is presented straight from the RAT during LOOKUP so a registered
  // PRF returns data in the following cycle; the register holds it afterwards.
  assign prf_raddr   = (state_reg == LOOKUP) ? rat_tag : raddr_reg;
  assign rat_idx     = idx_reg;
  assign dump_valid  = (state_reg == SEND);
  assign dump_done   = (state_reg == DONE);
  assign dump_idx    = dump_idx_reg;
  assign dump_data   = dump_data_reg;
  assign beat_accept = dump_valid & dump_ready;

`ifdef DUMP_CHECK_EN
  localparam int CNT_W = $clog2(NUM_AREG + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_AREG);

  logic [DATA_W-1:0] ref_arr [NUM_AREG];
  logic [CNT_W-1:0]  mismatch_cnt_reg, mismatch_cnt_next;

  for (genvar gi = 0; gi < NUM_AREG; gi++) begin : g_ref
    assign ref_arr[gi] = ref_data[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    mismatch_cnt_next = mismatch_cnt_reg;
    if (beat_accept && (dump_data_reg != ref_arr[dump_idx_reg]) &&
        (mismatch_cnt_reg != CNT_MAX)) begin
      mismatch_cnt_next = mismatch_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_cnt_reg <= '0;
    end else begin
      mismatch_cnt_reg <= mismatch_cnt_next;
    end
  end

  assign mismatch_cnt = mismatch_cnt_reg;
`endif

endmodule
